// File: rtl/elixirchip_es1_spu_sel_lt_arbiter.sv
// Round-robin arbiter that shares one pipelined sel_lt operator between NUM_REQ requesters.
// Each result comes back in issue order, tagged with the id of the requester that issued it.
module elixirchip_es1_spu_sel_lt_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned LATENCY   = 1,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned ID_BITS   = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           cke,

   input  logic [NUM_REQ-1:0]             s_req_valid,
   output logic [NUM_REQ-1:0]             s_req_ready,
   input  logic [NUM_REQ-1:0]             s_req_carry,
   input  logic [NUM_REQ-1:0]             s_req_msb_c,
   input  logic [NUM_REQ-1:0]             s_req_sign,
   input  logic [NUM_REQ-1:0]             s_req_clear,
   input  logic [NUM_REQ*DATA_BITS-1:0]   s_req_data0,
   input  logic [NUM_REQ*DATA_BITS-1:0]   s_req_data1,

   output logic                           m_op_carry,
   output logic                           m_op_msb_c,
   output logic                           m_op_sign,
   output logic                           m_op_clear,
   output logic                           m_op_valid,
   output logic [DATA_BITS-1:0]           m_op_data0,
   output logic [DATA_BITS-1:0]           m_op_data1,
   input  logic [DATA_BITS-1:0]           s_op_data,

   output logic                           m_res_valid,
   output logic [ID_BITS-1:0]             m_res_id,
   output logic [DATA_BITS-1:0]           m_res_data,
   output logic                           m_busy
);

   logic [ID_BITS-1:0]  last_grant_q;
   logic [NUM_REQ-1:0]  grant;
   logic [ID_BITS-1:0]  grant_id;
   logic                grant_any;
   logic [ID_BITS-1:0]  op_id_q;

   logic [LATENCY-1:0]  tag_valid_q;
   logic [ID_BITS-1:0]  tag_id_q [LATENCY];

   // Scan from the requester after the last winner; the first valid one takes the grant.
   always_comb begin
      logic [ID_BITS-1:0] idx;
      grant     = '0;
      grant_id  = '0;
      grant_any = 1'b0;
      idx       = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = ID_BITS'((int'(last_grant_q) + 1 + int'(k)) % int'(NUM_REQ));
         if (!grant_any && s_req_valid[idx]) begin
            grant_any   = 1'b1;
            grant[idx]  = 1'b1;
            grant_id    = idx;
         end
      end
   end

   assign s_req_ready = grant;

   // Issue register: also owns the round-robin pointer, which moves only on acceptance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant_q <= ID_BITS'(NUM_REQ - 1);
         op_id_q      <= '0;
         m_op_valid   <= 1'b0;
         m_op_carry   <= 1'b0;
         m_op_msb_c   <= 1'b0;
         m_op_sign    <= 1'b0;
         m_op_clear   <= 1'b0;
         m_op_data0   <= '0;
         m_op_data1   <= '0;
      end else if (cke) begin
         if (grant_any) begin
            last_grant_q <= grant_id;
            op_id_q      <= grant_id;
            m_op_valid   <= 1'b1;
            m_op_carry   <= s_req_carry[grant_id];
            m_op_msb_c   <= s_req_msb_c[grant_id];
            m_op_sign    <= s_req_sign[grant_id];
            m_op_clear   <= s_req_clear[grant_id];
            m_op_data0   <= s_req_data0[grant_id*DATA_BITS +: DATA_BITS];
            m_op_data1   <= s_req_data1[grant_id*DATA_BITS +: DATA_BITS];
         end else begin
            m_op_valid   <= 1'b0;
         end
      end
   end

   // Tag pipe runs in lockstep with the operator so the last stage marks when s_op_data is live.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_valid_q <= '0;
         for (int unsigned i = 0; i < LATENCY; i++) begin
            tag_id_q[i] <= '0;
         end
      end else if (cke) begin
         tag_valid_q[0] <= m_op_valid;
         tag_id_q[0]    <= op_id_q;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            tag_valid_q[i] <= tag_valid_q[i-1];
            tag_id_q[i]    <= tag_id_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_res_valid <= 1'b0;
         m_res_id    <= '0;
         m_res_data  <= '0;
      end else if (cke) begin
         if (tag_valid_q[LATENCY-1]) begin
            m_res_valid <= 1'b1;
            m_res_id    <= tag_id_q[LATENCY-1];
            m_res_data  <= s_op_data;
         end else begin
            m_res_valid <= 1'b0;
         end
      end
   end

   assign m_busy = m_op_valid | (|tag_valid_q);

endmodule

// File: tb/tb_elixirchip_es1_spu_sel_lt_arbiter.sv
// Directed bench for the sel_lt arbiter: grant table, hand-written corner sequences,
// and a random-cke phase, with an in-order result scoreboard and a stand-in operator model.
module tb_elixirchip_es1_spu_sel_lt_arbiter;

   localparam int unsigned NUM_REQ   = 4;
   localparam int unsigned LATENCY   = 1;
   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned ID_BITS   = 2;

   logic                         clk = 1'b0;
   logic                         reset;
   logic                         cke;
   logic [NUM_REQ-1:0]           s_req_valid;
   logic [NUM_REQ-1:0]           s_req_ready;
   logic [NUM_REQ-1:0]           s_req_carry;
   logic [NUM_REQ-1:0]           s_req_msb_c;
   logic [NUM_REQ-1:0]           s_req_sign;
   logic [NUM_REQ-1:0]           s_req_clear;
   logic [NUM_REQ*DATA_BITS-1:0] s_req_data0;
   logic [NUM_REQ*DATA_BITS-1:0] s_req_data1;
   logic                         m_op_carry;
   logic                         m_op_msb_c;
   logic                         m_op_sign;
   logic                         m_op_clear;
   logic                         m_op_valid;
   logic [DATA_BITS-1:0]         m_op_data0;
   logic [DATA_BITS-1:0]         m_op_data1;
   logic [DATA_BITS-1:0]         s_op_data;
   logic                         m_res_valid;
   logic [ID_BITS-1:0]           m_res_id;
   logic [DATA_BITS-1:0]         m_res_data;
   logic                         m_busy;

   int checks = 0;
   int passes = 0;

   elixirchip_es1_spu_sel_lt_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .LATENCY   (LATENCY),
      .DATA_BITS (DATA_BITS),
      .ID_BITS   (ID_BITS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cke         (cke),
      .s_req_valid (s_req_valid),
      .s_req_ready (s_req_ready),
      .s_req_carry (s_req_carry),
      .s_req_msb_c (s_req_msb_c),
      .s_req_sign  (s_req_sign),
      .s_req_clear (s_req_clear),
      .s_req_data0 (s_req_data0),
      .s_req_data1 (s_req_data1),
      .m_op_carry  (m_op_carry),
      .m_op_msb_c  (m_op_msb_c),
      .m_op_sign   (m_op_sign),
      .m_op_clear  (m_op_clear),
      .m_op_valid  (m_op_valid),
      .m_op_data0  (m_op_data0),
      .m_op_data1  (m_op_data1),
      .s_op_data   (s_op_data),
      .m_res_valid (m_res_valid),
      .m_res_id    (m_res_id),
      .m_res_data  (m_res_data),
      .m_busy      (m_busy)
   );

   always #5 clk = ~clk;

   // Stand-in sel_lt: clear yields 0, otherwise the smaller operand (signed when sign=1).
   function automatic logic [7:0] ref_op(input logic clr, input logic sgn,
                                         input logic [7:0] a, input logic [7:0] b);
      logic lt;
      if (clr) return 8'h00;
      lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
      return lt ? a : b;
   endfunction

   function automatic int model_idx(input logic [3:0] v, input logic [1:0] last);
      logic [1:0] idx;
      for (int k = 0; k < 4; k++) begin
         idx = last + 2'(k + 1);
         if (v[idx]) return int'(idx);
      end
      return -1;
   endfunction

   function automatic logic [3:0] model_grant(input logic [3:0] v, input logic [1:0] last);
      int i;
      i = model_idx(v, last);
      if (i < 0) return 4'b0000;
      return 4'(1 << i);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Operator model: LATENCY-deep pipe advancing on cke, like the real operator.
   logic [7:0] op_pipe [LATENCY];
   always @(posedge clk) begin
      if (cke) begin
         op_pipe[0] <= ref_op(m_op_clear, m_op_sign, m_op_data0, m_op_data1);
         for (int i = 1; i < LATENCY; i++) op_pipe[i] <= op_pipe[i-1];
      end
   end
   assign s_op_data = op_pipe[LATENCY-1];

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   exp_t       sb [$];
   logic [1:0] exp_last;

   // Scoreboard: push on modelled acceptance, pop on each fresh result strobe.
   always @(posedge clk) begin
      int   gi;
      logic c;
      exp_t e;
      if (!reset) begin
         sb.delete();
         exp_last = 2'd3;
      end else begin
         c = cke;
         if (cke) begin
            gi = model_idx(s_req_valid, exp_last);
            if (gi >= 0) begin
               e.id   = 2'(gi);
               e.data = ref_op(s_req_clear[gi], s_req_sign[gi],
                               s_req_data0[gi*8 +: 8], s_req_data1[gi*8 +: 8]);
               sb.push_back(e);
               exp_last = 2'(gi);
            end
         end
         #1;
         if (reset && c && m_res_valid) begin
            if (sb.size() == 0) begin
               checks++;
               $display("FAIL res_unexpected: got id %0h data %0h expected no result at %0t",
                        m_res_id, m_res_data, $time);
            end else begin
               e = sb.pop_front();
               check("res_id", 32'(m_res_id), 32'(e.id));
               check("res_data", 32'(m_res_data), 32'(e.data));
            end
         end
      end
   end

   task automatic drive(input logic c, input logic [3:0] v);
      @(negedge clk);
      cke         = c;
      s_req_valid = v;
      #1;
   endtask

   task automatic rand_inputs();
      s_req_data0 = 32'($urandom);
      s_req_data1 = 32'($urandom);
      s_req_sign  = 4'($urandom);
      s_req_carry = 4'($urandom);
      s_req_msb_c = 4'($urandom);
      for (int i = 0; i < 4; i++) s_req_clear[i] = ($urandom_range(0, 7) == 0);
   endtask

   typedef struct {
      logic       c;
      logic [3:0] v;
      logic [3:0] r;
   } vec_t;

   vec_t tbl [18];

   initial begin
      tbl[0]  = '{1'b1, 4'b1111, 4'b0001};
      tbl[1]  = '{1'b1, 4'b1111, 4'b0010};
      tbl[2]  = '{1'b1, 4'b1111, 4'b0100};
      tbl[3]  = '{1'b1, 4'b1111, 4'b1000};
      tbl[4]  = '{1'b1, 4'b1111, 4'b0001};
      tbl[5]  = '{1'b1, 4'b1111, 4'b0010};
      tbl[6]  = '{1'b1, 4'b1010, 4'b1000};
      tbl[7]  = '{1'b1, 4'b1010, 4'b0010};
      tbl[8]  = '{1'b1, 4'b0000, 4'b0000};
      tbl[9]  = '{1'b0, 4'b0101, 4'b0100};
      tbl[10] = '{1'b1, 4'b0101, 4'b0100};
      tbl[11] = '{1'b1, 4'b0100, 4'b0100};
      tbl[12] = '{1'b1, 4'b0100, 4'b0100};
      tbl[13] = '{1'b1, 4'b0001, 4'b0001};
      tbl[14] = '{1'b1, 4'b1001, 4'b1000};
      tbl[15] = '{1'b1, 4'b1110, 4'b0010};
      tbl[16] = '{1'b1, 4'b1100, 4'b0100};
      tbl[17] = '{1'b1, 4'b0000, 4'b0000};

      reset       = 1'b0;
      cke         = 1'b0;
      s_req_valid = '0;
      s_req_carry = '0;
      s_req_msb_c = '0;
      s_req_sign  = '0;
      s_req_clear = '0;
      s_req_data0 = '0;
      s_req_data1 = '0;
      repeat (2) @(negedge clk);
      check("rst_op_valid", 32'(m_op_valid), 32'd0);
      check("rst_op_data0", 32'(m_op_data0), 32'd0);
      check("rst_res_valid", 32'(m_res_valid), 32'd0);
      check("rst_res_id", 32'(m_res_id), 32'd0);
      check("rst_res_data", 32'(m_res_data), 32'd0);
      check("rst_busy", 32'(m_busy), 32'd0);
      s_req_valid = 4'b1111;
      #1;
      check("rst_ready_prio0", 32'(s_req_ready), 32'b0001);
      s_req_valid = '0;
      @(negedge clk);
      reset = 1'b1;

      // Grant table, including the all-valid rotation, 1&3 after grant 1, withdrawal and cke=0.
      for (int i = 0; i < 18; i++) begin
         rand_inputs();
         drive(tbl[i].c, tbl[i].v);
         check($sformatf("tbl_ready[%0d]", i), 32'(s_req_ready), 32'(tbl[i].r));
      end
      repeat (4) drive(1'b1, 4'b0000);
      check("idle_busy", 32'(m_busy), 32'd0);

      // Single requester 2 with fixed operands; result three cycles after acceptance.
      s_req_data0 = 32'h0010_0000;
      s_req_data1 = 32'h0020_0000;
      s_req_sign  = '0;
      s_req_clear = '0;
      drive(1'b1, 4'b0100);
      check("r2_ready", 32'(s_req_ready), 32'b0100);
      @(posedge clk); #2;
      check("r2_op_valid", 32'(m_op_valid), 32'd1);
      check("r2_op_data0", 32'(m_op_data0), 32'h10);
      check("r2_op_data1", 32'(m_op_data1), 32'h20);
      @(negedge clk);
      s_req_valid = '0;
      @(posedge clk); #2;
      check("r2_res_early", 32'(m_res_valid), 32'd0);
      check("r2_busy", 32'(m_busy), 32'd1);
      @(posedge clk); #2;
      check("r2_res_valid", 32'(m_res_valid), 32'd1);
      check("r2_res_id", 32'(m_res_id), 32'd2);
      check("r2_res_data", 32'(m_res_data), 32'h10);
      check("r2_busy_done", 32'(m_busy), 32'd0);

      // Clear on requester 0 propagates to the operator and its clear result returns with id 0.
      s_req_clear = 4'b0001;
      drive(1'b1, 4'b0001);
      @(posedge clk); #2;
      check("clr_op_clear", 32'(m_op_clear), 32'd1);
      @(negedge clk);
      s_req_valid = '0;
      s_req_clear = '0;
      @(posedge clk);
      @(posedge clk); #2;
      check("clr_res_valid", 32'(m_res_valid), 32'd1);
      check("clr_res_id", 32'(m_res_id), 32'd0);
      check("clr_res_data", 32'(m_res_data), 32'd0);

      // cke low freezes the issue register and the tag pipe.
      rand_inputs();
      drive(1'b1, 4'b1000);
      drive(1'b0, 4'b0000);
      drive(1'b0, 4'b0110);
      check("hold_op_valid", 32'(m_op_valid), 32'd1);
      check("hold_busy", 32'(m_busy), 32'd1);
      check("hold_res_valid", 32'(m_res_valid), 32'd0);
      repeat (4) drive(1'b1, 4'b0000);

      // Random traffic with cke low about 10% of cycles.
      for (int i = 0; i < 300; i++) begin
         logic       c;
         logic [3:0] v;
         rand_inputs();
         c = ($urandom_range(0, 9) != 0);
         v = 4'($urandom);
         drive(c, v);
         check("rand_ready", 32'(s_req_ready), 32'(model_grant(v, exp_last)));
      end
      repeat (LATENCY + 4) drive(1'b1, 4'b0000);
      check("rand_drained", 32'(sb.size()), 32'd0);

      // Reset with operations in flight: nothing from before reset may come back.
      for (int i = 0; i < 3; i++) begin
         rand_inputs();
         drive(1'b1, 4'b1111);
      end
      @(negedge clk);
      s_req_valid = '0;
      reset       = 1'b0;
      #1;
      check("mid_rst_res_valid", 32'(m_res_valid), 32'd0);
      check("mid_rst_op_valid", 32'(m_op_valid), 32'd0);
      check("mid_rst_busy", 32'(m_busy), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 4'b0000);
         check("post_rst_res_valid", 32'(m_res_valid), 32'd0);
      end
      drive(1'b1, 4'b0010);
      check("post_rst_ready", 32'(s_req_ready), 32'b0010);
      repeat (LATENCY + 4) drive(1'b1, 4'b0000);
      check("final_drained", 32'(sb.size()), 32'd0);
      check("final_busy", 32'(m_busy), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/elixirchip_es1_spu_sel_lt_arbiter.md
ELIXIRCHIP_ES1_SPU_SEL_LT_ARBITER -- requirements
Module: elixirchip_es1_spu_sel_lt_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one sel_lt operator (2..8).
REQ-002 Parameter LATENCY, default 1: operator pipeline depth in cke-qualified cycles (1..8).
REQ-003 Parameter DATA_BITS, default 8: operand/result width.
REQ-004 Parameter ID_BITS, default $clog2(NUM_REQ): requester-id width.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 cke  input  1  global clock enable; when 0 all state holds.
REQ-008 s_req_valid  input  NUM_REQ  per-requester request.
REQ-009 s_req_ready  output  NUM_REQ  one-hot grant; request accepted when valid&ready&cke.
REQ-010 s_req_carry, s_req_msb_c, s_req_sign, s_req_clear  input  NUM_REQ each  per-requester flags.
REQ-011 s_req_data0, s_req_data1  input  NUM_REQ*DATA_BITS each  packed operands, requester i at [i*DATA_BITS +: DATA_BITS].
REQ-012 m_op_carry, m_op_msb_c, m_op_sign, m_op_clear, m_op_valid  output  1 each  registered drive to operator.
REQ-013 m_op_data0, m_op_data1  output  DATA_BITS each  registered operands to operator.
REQ-014 s_op_data  input  DATA_BITS  operator result, valid LATENCY cke-cycles after m_op_* issue.
REQ-015 m_res_valid  output  1  result strobe.
REQ-016 m_res_id  output  ID_BITS  requester owning m_res_data.
REQ-017 m_res_data  output  DATA_BITS  result (s_op_data sampled on the matching cycle).
REQ-018 m_busy  output  1  high while any issued operation has not yet returned.

Function
REQ-019 Grant SHALL be round-robin: priority starts at requester (last_grant+1) mod NUM_REQ; lowest-index wins after rotation.
REQ-020 s_req_ready SHALL be combinational from s_req_valid and last_grant, at most one bit set, zero when no valid.
REQ-021 last_grant SHALL update only on an accepted request (valid&ready&cke).
REQ-022 On acceptance, granted requester's flags/operands SHALL be registered onto m_op_* with m_op_valid=1 next cycle; with no acceptance and cke=1, m_op_valid SHALL become 0, other m_op_* hold.
REQ-023 With cke=0, m_op_*, grant pointer, tag pipe and m_res_* SHALL hold; s_req_ready SHALL still be driven but no acceptance occurs.
REQ-024 Tag pipe: LATENCY stages of {valid, id, clear}, shifting on cke; stage 0 loaded from the issue register.
REQ-025 When final tag stage valid=1 (cke=1), m_res_valid=1, m_res_id=tag id, m_res_data=s_op_data, registered one cycle after; otherwise m_res_valid=0, id/data hold.
REQ-026 Throughput SHALL be one accepted request per cke cycle; total request-to-result latency = LATENCY+2 cke cycles.
REQ-027 Issue order SHALL equal result order; no reordering, no result drop.
REQ-028 m_busy SHALL be OR of issue-register valid and all tag-stage valids.
REQ-029 Requester withdrawing valid before grant SHALL lose nothing; pointer unchanged.
REQ-030 Single active requester SHALL be granted every cke cycle.

Reset
REQ-031 reset=0 SHALL immediately clear: m_op_* all 0, m_res_valid=0, m_res_id=0, m_res_data=0, all tag valids 0, last_grant=NUM_REQ-1 (so requester 0 has first priority), m_busy=0.
REQ-032 Reset mid-operation SHALL discard in-flight tags; no m_res_valid after release for pre-reset requests.
REQ-033 Reset release SHALL be synchronised externally; first acceptance possible on first cke cycle after release.

Verification
REQ-034 All 4 valid constantly, cke=1 -> grants 0,1,2,3,0,... ; m_res_id sequence 0,1,2,3 starting LATENCY+2 cycles after first grant.
REQ-035 Only requester 2 valid, data0=0x10, data1=0x20, LATENCY=1 -> ready[2]=1 every cycle; m_op_data0=0x10 next cycle; m_res_id=2 three cycles after acceptance.
REQ-036 Random cke (10% low) with random requests -> scoreboard: every accepted request returns exactly once, in order, id matches, result equals reference sel_lt model.
REQ-037 Request from 1 and 3 while last_grant=1 -> grant 3, then 1.
REQ-038 reset=0 asserted with 3 operations in flight -> m_res_valid=0 immediately and stays 0 after release until new requests.
REQ-039 s_req_clear=1 on requester 0 -> m_op_clear=1 next cycle, m_res_data equals operator clear value with m_res_id=0.
